// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to single-memory arbiter with round-robin tie-break,
// one transaction in flight, and a sticky WAIT-state timeout flag.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e        state_q, state_d;
  owner_e        last_grant_q, last_grant_d;
  owner_e        owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   ifu_rdata_q, ifu_rdata_d;
  logic [31:0]   lsu_rdata_q, lsu_rdata_d;
  logic          grant_ifu, grant_lsu;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wen_d         = wen_q;
    wmask_d       = wmask_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;

    // IFU wins outright, or on a tie when the LSU was served last.
    grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant_q == OWN_LSU);
    grant_lsu = lsu_req_valid && !grant_ifu;

    unique case (state_q)
      S_IDLE: begin
        ifu_req_ready = grant_ifu && rst;
        lsu_req_ready = grant_lsu && rst;
        if (grant_ifu) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wen_d        = 1'b0;
          wmask_d      = '0;
          state_d      = S_REQ;
        end else if (grant_lsu) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = lsu_addr;
          wdata_d      = lsu_wdata;
          wen_d        = lsu_wen;
          wmask_d      = lsu_wmask;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the final counted cycle still completes normally.
        if (mem_resp_valid) begin
          if (owner_q == OWN_IFU) ifu_rdata_d = mem_rdata;
          else                    lsu_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          if (owner_q == OWN_IFU) ifu_rdata_d = '0;
          else                    lsu_rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_addr       = mem_req_valid ? addr_q  : '0;
  assign mem_wdata      = mem_req_valid ? wdata_q : '0;
  assign mem_wen        = mem_req_valid && wen_q;
  assign mem_wmask      = mem_req_valid ? wmask_q : '0;
  assign ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign timeout_err    = timeout_q;

endmodule
